// File: rtl/multi_flux_shifter.sv
// Multi-flux dataflow shifter: arbitrates FLUX tagged input FIFOs, applies a per-flux
// runtime right shift and writes {tag, result} through a 2-entry skid buffer.
module multi_flux_shifter #(
    parameter int unsigned DATA_WIDTH = 27,
    parameter int unsigned FLUX       = 2,
    parameter int unsigned TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int unsigned SHIFT_W    = $clog2(DATA_WIDTH + 1),
    parameter int unsigned ARB_RR     = 0,
    parameter int unsigned ARITH      = 0,
    parameter int unsigned ROUND      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX*SHIFT_W-1:0]         cfg_shift,
    input  logic [FLUX-1:0]                 read_port_empty,
    input  logic [FLUX*DATA_WIDTH-1:0]      read_port_dout,
    output logic [FLUX-1:0]                 read_port_read,
    input  logic                            write_port_full,
    output logic                            write_port_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] write_port_din
);
    localparam int unsigned XW = DATA_WIDTH + 1;
    localparam int unsigned OW = TAG_WIDTH + DATA_WIDTH;

    logic                  r_armed;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [TAG_WIDTH-1:0]  r_s1_tag;
    logic [SHIFT_W-1:0]    r_s1_shift;
    logic [1:0]            r_cnt;
    logic [OW-1:0]         r_head;
    logic [OW-1:0]         r_tail;
    logic [TAG_WIDTH-1:0]  r_ptr;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_room;
    logic                  w_hit;
    logic                  w_fire;
    logic [2:0]            w_occ;
    logic [TAG_WIDTH-1:0]  w_win;
    logic [TAG_WIDTH-1:0]  w_idx;
    logic                  w_sign;
    logic [XW-1:0]         w_ext;
    logic [XW-1:0]         w_sum;
    logic [XW-1:0]         w_shr;
    logic [DATA_WIDTH-1:0] w_res;
    logic [OW-1:0]         w_word;

    // Occupancy after this cycle's pop, counting the word already in S1, must leave a free slot.
    assign w_pop  = (r_cnt != 2'd0) && !write_port_full;
    assign w_push = r_s1_valid;
    assign w_occ  = 3'(r_cnt) + 3'(r_s1_valid) - 3'(w_pop);
    assign w_room = r_armed && (w_occ < 3'd2);
    assign w_fire = w_room && w_hit;

    assign read_port_read   = w_fire ? (FLUX'(1) << w_win) : '0;
    assign write_port_write = w_pop;
    assign write_port_din   = r_head;

    // Arbiter: round-robin from ptr+1, or highest non-empty index.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_idx = '0;
        if (ARB_RR != 0) begin
            for (int unsigned k = 1; k <= FLUX; k++) begin
                w_idx = TAG_WIDTH'((32'(r_ptr) + k) % FLUX);
                if (!w_hit && !read_port_empty[w_idx]) begin
                    w_hit = 1'b1;
                    w_win = w_idx;
                end
            end
        end else begin
            for (int unsigned k = 0; k < FLUX; k++) begin
                if (!read_port_empty[k]) begin
                    w_hit = 1'b1;
                    w_win = TAG_WIDTH'(k);
                end
            end
        end
    end

    // S2 shifter; the extra top bit absorbs the rounding increment.
    always_comb begin
        w_sign = (ARITH != 0) && r_s1_data[DATA_WIDTH-1];
        w_ext  = {w_sign, r_s1_data};
        w_sum  = w_ext;
        if ((ROUND != 0) && (r_s1_shift != '0)) begin
            w_sum = w_ext + (XW'(1) << (r_s1_shift - SHIFT_W'(1)));
        end
        if (ARITH != 0) begin
            w_shr = XW'($signed(w_sum) >>> r_s1_shift);
        end else begin
            w_shr = w_sum >> r_s1_shift;
        end
        if (r_s1_shift == '0) begin
            w_res = r_s1_data;
        end else if (32'(r_s1_shift) >= DATA_WIDTH) begin
            w_res = {DATA_WIDTH{w_sign}};
        end else begin
            w_res = w_shr[DATA_WIDTH-1:0];
        end
        w_word = {r_s1_tag, w_res};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_shift <= '0;
            r_cnt      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_ptr      <= TAG_WIDTH'(FLUX - 1);
        end else begin
            r_armed    <= 1'b1;
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_data  <= read_port_dout[32'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_s1_tag   <= w_win;
                r_s1_shift <= cfg_shift[32'(w_win)*SHIFT_W +: SHIFT_W];
                if (ARB_RR != 0) begin
                    r_ptr <= w_win;
                end
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            // Head register is the output word; tail only holds the second entry.
            if (w_pop) begin
                if (r_cnt == 2'd2) begin
                    r_head <= r_tail;
                    if (w_push) begin
                        r_tail <= w_word;
                    end
                end else if (w_push) begin
                    r_head <= w_word;
                end
            end else if (w_push) begin
                if (r_cnt == 2'd0) begin
                    r_head <= w_word;
                end else begin
                    r_tail <= w_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_flux_shifter.sv
// Directed bench for multi_flux_shifter: three instances (fixed-priority logical,
// round-robin with 4 fluxes, arithmetic with rounding) fed from FWFT source models.
module tb_multi_flux_shifter;
    localparam int unsigned DW = 27;
    localparam int unsigned SW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [2*SW-1:0] fp_shift, ar_shift;
    logic [4*SW-1:0] rr_shift;
    logic [1:0]      fp_empty, fp_read, ar_empty, ar_read;
    logic [3:0]      rr_empty, rr_read;
    logic [2*DW-1:0] fp_dout, ar_dout;
    logic [4*DW-1:0] rr_dout;
    logic            fp_full, fp_write, ar_full, ar_write, rr_full, rr_write;
    logic [DW:0]     fp_din, ar_din;
    logic [DW+1:0]   rr_din;

    multi_flux_shifter #(.DATA_WIDTH(DW), .FLUX(2), .ARB_RR(0), .ARITH(0), .ROUND(0)) u_fp (
        .clk(clk), .rst(rst), .cfg_shift(fp_shift), .read_port_empty(fp_empty),
        .read_port_dout(fp_dout), .read_port_read(fp_read), .write_port_full(fp_full),
        .write_port_write(fp_write), .write_port_din(fp_din));

    multi_flux_shifter #(.DATA_WIDTH(DW), .FLUX(4), .ARB_RR(1), .ARITH(0), .ROUND(0)) u_rr (
        .clk(clk), .rst(rst), .cfg_shift(rr_shift), .read_port_empty(rr_empty),
        .read_port_dout(rr_dout), .read_port_read(rr_read), .write_port_full(rr_full),
        .write_port_write(rr_write), .write_port_din(rr_din));

    multi_flux_shifter #(.DATA_WIDTH(DW), .FLUX(2), .ARB_RR(0), .ARITH(1), .ROUND(1)) u_ar (
        .clk(clk), .rst(rst), .cfg_shift(ar_shift), .read_port_empty(ar_empty),
        .read_port_dout(ar_dout), .read_port_read(ar_read), .write_port_full(ar_full),
        .write_port_write(ar_write), .write_port_din(ar_din));

    // Source FIFOs, index 0 = fp, 1 = rr, 2 = ar.
    logic [DW-1:0] mem [3][4][64];
    int wp [3][4] = '{default: 0};
    int rp [3][4] = '{default: 0};

    always_comb begin
        for (int f = 0; f < 2; f++) begin
            fp_empty[f]          = (rp[0][f] == wp[0][f]);
            fp_dout[f*DW +: DW]  = mem[0][f][rp[0][f] % 64];
            ar_empty[f]          = (rp[2][f] == wp[2][f]);
            ar_dout[f*DW +: DW]  = mem[2][f][rp[2][f] % 64];
        end
        for (int f = 0; f < 4; f++) begin
            rr_empty[f]          = (rp[1][f] == wp[1][f]);
            rr_dout[f*DW +: DW]  = mem[1][f][rp[1][f] % 64];
        end
    end

    always @(posedge clk) begin
        for (int f = 0; f < 4; f++) begin
            if (f < 2 && fp_read[f]) rp[0][f] <= rp[0][f] + 1;
            if (rr_read[f])          rp[1][f] <= rp[1][f] + 1;
            if (f < 2 && ar_read[f]) rp[2][f] <= rp[2][f] + 1;
        end
    end

    logic [31:0] fp_oq[$], rr_oq[$], ar_oq[$];
    int          fp_oc[$], fp_gc[$], rr_oc[$], rr_gc[$];
    logic [3:0]  fp_gq[$], rr_gq[$];

    always @(negedge clk) begin
        if (fp_write) begin fp_oq.push_back(32'(fp_din)); fp_oc.push_back(cyc); end
        if (fp_read != 2'b00) begin fp_gq.push_back(4'(fp_read)); fp_gc.push_back(cyc); end
        if (rr_write) begin rr_oq.push_back(32'(rr_din)); rr_oc.push_back(cyc); end
        if (rr_read != 4'b0000) begin rr_gq.push_back(rr_read); rr_gc.push_back(cyc); end
        if (ar_write) ar_oq.push_back(32'(ar_din));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int u, input int f, input logic [DW-1:0] v);
        mem[u][f][wp[u][f]] = v;
        wp[u][f] = wp[u][f] + 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int base;
    int gbase;

    initial begin
        fp_shift = {5'd11, 5'd11};
        rr_shift = '0;
        ar_shift = {5'd27, 5'd4};
        fp_full  = 1'b0;
        rr_full  = 1'b0;
        ar_full  = 1'b0;
        push(0, 1, 27'h7FFFFFF);
        push(0, 0, 27'h0000800);
        #1 rst = 1'b0;
        #1;
        chk("rst_read",  64'(fp_read),  64'h0);
        chk("rst_write", 64'(fp_write), 64'h0);
        chk("rst_din",   64'(fp_din),   64'h0);
        chk("rst_rr_rd", 64'(rr_read),  64'h0);
        step(2);
        rst = 1'b1;
        #1;
        chk("rel_read", 64'(fp_read), 64'h0);

        // Fixed priority, shift 11 on both lanes.
        step(8);
        chk("t1_count", 64'(fp_oq.size()), 64'd2);
        chk("t1_gnt0",  64'(fp_gq[0]), 64'h2);
        chk("t1_gnt1",  64'(fp_gq[1]), 64'h1);
        chk("t1_out0",  64'(fp_oq[0]), 64'h800FFFF);
        chk("t1_out1",  64'(fp_oq[1]), 64'h0000001);
        chk("t1_lat",   64'(fp_oc[0] - fp_gc[0]), 64'd2);

        // s=0 on flux0, s=27 on flux1 (logical -> 0).
        fp_shift = {5'd27, 5'd0};
        base = fp_oq.size();
        push(0, 0, 27'h5A5A5A5);
        push(0, 1, 27'h7FFFFFF);
        step(8);
        chk("t2_count", 64'(fp_oq.size() - base), 64'd2);
        chk("t2_s27",   64'(fp_oq[base]),     64'h8000000);
        chk("t2_s0",    64'(fp_oq[base + 1]), 64'h5A5A5A5);

        // Back-pressure: only two words admitted while full, then an in-order drain.
        base  = fp_oq.size();
        gbase = fp_gq.size();
        fp_full = 1'b1;
        for (int i = 0; i < 10; i++) push(0, 0, 27'(32'h100 + i));
        step(10);
        chk("stall_reads",  64'(fp_gq.size() - gbase), 64'd2);
        chk("stall_writes", 64'(fp_oq.size() - base),  64'd0);
        fp_full = 1'b0;
        step(16);
        chk("drain_count", 64'(fp_oq.size() - base), 64'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("drain%0d", i), 64'(fp_oq[base + i]), 64'(32'h100 + i));
        chk("drain_rate", 64'(fp_oc[base + 9] - fp_oc[base]), 64'd9);

        // Reset with two buffered words discards them.
        base = fp_oq.size();
        fp_full = 1'b1;
        for (int i = 0; i < 6; i++) push(0, 0, 27'(32'h200 + i));
        step(6);
        fp_full = 1'b0;
        #2;
        chk("pre_rst_write", 64'(fp_write), 64'h1);
        rst = 1'b0;
        #1;
        chk("arst_write", 64'(fp_write), 64'h0);
        chk("arst_read",  64'(fp_read),  64'h0);
        chk("arst_din",   64'(fp_din),   64'h0);
        step(2);
        rst = 1'b1;
        step(12);
        chk("post_rst_count", 64'(fp_oq.size() - base), 64'd4);
        chk("post_rst_first", 64'(fp_oq[base]),     64'h202);
        chk("post_rst_last",  64'(fp_oq[base + 3]), 64'h205);

        // Round-robin across 4 fluxes, two words each.
        for (int k = 0; k < 2; k++)
            for (int f = 0; f < 4; f++) push(1, f, 27'(f * 16 + k));
        step(16);
        chk("rr_count", 64'(rr_oq.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_gnt%0d", i), 64'(rr_gq[i]), 64'(4'b0001 << (i % 4)));
            chk($sformatf("rr_out%0d", i), 64'(rr_oq[i]),
                64'((32'(i % 4) << 27) | 32'((i % 4) * 16 + i / 4)));
        end
        chk("rr_lat", 64'(rr_oc[0] - rr_gc[0]), 64'd2);

        // Arithmetic shift with round-half-up (toward +inf): s=4 on flux0, s=27 on flux1.
        push(2, 0, 27'h7FFFFF8);   // -8/16 = -0.5 -> 0
        push(2, 0, 27'h0000018);   // 24/16 = 1.5 -> 2
        push(2, 0, 27'h7FFFFF7);   // -9/16 = -0.5625 -> -1
        push(2, 1, 27'h4000000);   // negative, s=27 -> all ones
        push(2, 1, 27'h0000123);   // positive, s=27 -> 0
        step(14);
        chk("ar_count", 64'(ar_oq.size()), 64'd5);
        chk("ar_s27_neg", 64'(ar_oq[0]), 64'hFFFFFFF);
        chk("ar_s27_pos", 64'(ar_oq[1]), 64'h8000000);
        chk("ar_m8",      64'(ar_oq[2]), 64'h0000000);
        chk("ar_p24",     64'(ar_oq[3]), 64'h0000002);
        chk("ar_m9",      64'(ar_oq[4]), 64'h7FFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
